mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store sequencer for the RISC-V core. It accepts one load or store per request from the pipeline and checks alignment. It drives a single-outstanding req/ack data-memory bus with byte enables and replicated store lanes. Load results go out right-shifted to byte lane 0, unextended; the downstream part-selector stage applies sign/zero extension by funct3.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum bus-wait cycles before an access fault (1..65535).
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: pipeline request; pipeline holds all `req_*` stable while `busy`.
- `req_load` in 1: 1 = load, 0 = store.
- `req_funct3` in 3: RV32I width code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `busy` out 1: pipeline stall.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: one-cycle fault pulse.
- `fault_code` out 2: 01 misaligned, 10 timeout, 11 illegal funct3; valid with `fault`.
- `ld_valid` out 1: `done` & load; drives downstream `trueop`.
- `ld_funct3` out 3: registered funct3 of the completed load.
- `rdata_aligned` out 32: `mem_rdata >> (8*addr[1:0])`, zero-filled from the top.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 (bits [1:0] = 0), `mem_be` out 4, `mem_wdata` out 32.
- `mem_rdata` in 32, `mem_ack` in 1.

## Operation
- States are IDLE and BUS.
- IDLE, `req_valid`=1, legal and aligned request:
  - Register addr, we, be, wdata and funct3; go to BUS.
  - `busy`=1 combinationally in this cycle.
- IDLE, illegal funct3:
  - Loads: legal codes are 0,1,2,4,5. Stores: legal codes are 0,1,2.
  - Raise `fault`=1, code 11, next cycle. No bus access; stay in IDLE.
- IDLE, misaligned:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Raise `fault`=1, code 01, next cycle. No bus access.
- Illegal funct3 takes priority over misalignment.
- Lane steering:
  - Byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: be = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata unchanged.
  - Loads drive the same be; memory may ignore it.
- BUS:
  - `mem_req`=1 with addr/we/be/wdata held constant until `mem_ack`.
  - On ack: capture `rdata_aligned` (loads only; it holds its previous value on stores). Pulse `done` next cycle; return to IDLE.
- Timeout counter:
  - Clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: drop `mem_req`, pulse `fault` code 10, return to IDLE.
  - Ack in the same cycle as timeout: ack wins, normal completion.
- `req_valid` while in BUS is ignored. No new request is accepted in the cycle `done` or `fault` is high. `busy` is low in that cycle, so the pipeline advances.
- `done` and `fault` are never high together.

## Timing
- Reset values: every output is 0, state IDLE, counter 0. `rdata_aligned` and `ld_funct3` also reset to 0.
- Reset asserted mid-BUS: `mem_req` falls immediately (asynchronously). No `done` or `fault` is generated; an in-flight ack after reset is ignored.
- Accepted at cycle 0 → `mem_req` high at cycle 1. Ack at cycle k≥1 → `done` at k+1, `mem_req` low at k+1. Minimum latency is 2 cycles.
- Fault path: request at cycle 0 → `fault` at cycle 1.
- `busy` is high from cycle 0 through cycle k, and low in the `done`/`fault` cycle.
- Timeout: no ack → `fault` code 10 exactly `TIMEOUT_CYCLES`+1 cycles after `mem_req` rises.
- Back-to-back: a new request presented in the `done` cycle is evaluated in the following cycle.

## Structure
- Shared package `lsu_pkg` holds:
  - state encoding (IDLE, BUS);
  - fault codes (FLT_MISALIGN=2'b01, FLT_TIMEOUT=2'b10, FLT_FUNCT3=2'b11);
  - funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2).
- Sub-module `lane_steer` (combinational) takes funct3, addr[1:0], wdata, load. It produces be, replicated wdata, misaligned and illegal.
- The top level holds the FSM, timeout counter, bus registers and load-data shift.

## Test plan
- LW addr 0x100, mem ack cycle 1 with rdata 0xDEADBEEF → mem_addr 0x100, be 1111, done at cycle 2, rdata_aligned 0xDEADBEEF, ld_funct3 2.
- LB addr 0x103, rdata 0x80112233, ack after 3 wait cycles → be 1000, rdata_aligned 0x00000080, done 5 cycles after accept.
- SH addr 0x202, wdata 0x0000ABCD → mem_we 1, be 1100, mem_wdata 0xABCDABCD, mem_addr 0x200, done, ld_valid 0.
- LH addr 0x101 → fault 1, code 01, mem_req never high. LW funct3 3 → code 11. SB funct3 4 → code 11.
- TIMEOUT_CYCLES=4, no ack → fault code 10 exactly 5 cycles after mem_req rises; mem_req low that cycle. Repeat with ack on cycle 4 → done, no fault.
- Reset pulsed 2 cycles into BUS → mem_req, busy and done all 0 immediately; a late ack produces nothing; the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store sequencer.
package lsu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_FUNCT3   = 2'b11;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  // Move the addressed byte/half/word down to lane 0, zero-filling the top.
  function automatic logic [31:0] align_load(input logic [31:0] data, input logic [1:0] offset);
    return data >> {offset, 3'b000};
  endfunction

endpackage

// File: rtl/lane_steer.sv
// Combinational byte-lane steering and request legality checks.
module lane_steer
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic        load,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic        illegal
);

  // Width comes from funct3[1:0]; funct3[2] only selects unsigned loads.
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    illegal    = load ? !(funct3 inside {LB, LH, LW, LBU, LHU})
                      : !(funct3 inside {SB, SH, SW});
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << offset;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        be         = 4'b1111;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: single-outstanding req/ack bus master
// with alignment/funct3 checking and a bus-wait timeout.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        ld_valid,
  output logic [2:0]  ld_funct3,
  output logic [31:0] rdata_aligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic [15:0] count_reg;
  logic [31:0] addr_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        done_reg;
  logic        fault_reg;
  logic [1:0]  fault_code_reg;
  logic [2:0]  ld_funct3_reg;
  logic [31:0] rdata_reg;

  logic [3:0]  steer_be;
  logic [31:0] steer_wdata;
  logic        steer_misaligned;
  logic        steer_illegal;

  logic        accept;
  logic        reject;
  logic [1:0]  reject_code;
  logic        complete;
  logic        timeout;

  lane_steer u_lane_steer (
    .funct3     (req_funct3),
    .offset     (req_addr[1:0]),
    .wdata      (req_wdata),
    .load       (req_load),
    .be         (steer_be),
    .wdata_rep  (steer_wdata),
    .misaligned (steer_misaligned),
    .illegal    (steer_illegal)
  );

  // Next-state and request decode; the done/fault pulse cycle blocks acceptance
  // so a request presented then is evaluated one cycle later.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    reject      = 1'b0;
    reject_code = FLT_MISALIGN;
    complete    = 1'b0;
    timeout     = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid && !done_reg && !fault_reg) begin
          busy = 1'b1;
          if (steer_illegal) begin
            reject      = 1'b1;
            reject_code = FLT_FUNCT3;
          end else if (steer_misaligned) begin
            reject      = 1'b1;
            reject_code = FLT_MISALIGN;
          end else begin
            accept     = 1'b1;
            state_next = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        busy = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (count_reg == TIMEOUT_LIMIT) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Stall must vanish the instant reset is asserted, even with req_valid held.
    if (rst) busy = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Bus-wait counter: cleared on entry to BUS, counts cycles without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  count_reg <= '0;
    else if (accept)                          count_reg <= '0;
    else if (state_reg == ST_BUS && !mem_ack) count_reg <= count_reg + 16'd1;
  end

  // Bus request registers, held constant for the whole BUS phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      be_reg     <= '0;
      wdata_reg  <= '0;
      funct3_reg <= '0;
    end else if (accept) begin
      addr_reg   <= {req_addr[31:2], 2'b00} | {30'd0, req_addr[1:0]};
      we_reg     <= !req_load;
      be_reg     <= steer_be;
      wdata_reg  <= steer_wdata;
      funct3_reg <= req_funct3;
    end
  end

  // One-cycle completion/fault pulses; the fault code is held until the next fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg       <= 1'b0;
      fault_reg      <= 1'b0;
      fault_code_reg <= '0;
    end else begin
      done_reg  <= complete;
      fault_reg <= reject || timeout;
      if (reject)       fault_code_reg <= reject_code;
      else if (timeout) fault_code_reg <= FLT_TIMEOUT;
    end
  end

  // Load result capture; stores leave the previous load data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg     <= '0;
      ld_funct3_reg <= '0;
    end else if (complete && !we_reg) begin
      rdata_reg     <= align_load(mem_rdata, addr_reg[1:0]);
      ld_funct3_reg <= funct3_reg;
    end
  end

  assign mem_req       = (state_reg == ST_BUS);
  assign mem_we        = we_reg;
  assign mem_addr      = {addr_reg[31:2], 2'b00};
  assign mem_be        = be_reg;
  assign mem_wdata     = wdata_reg;
  assign done          = done_reg;
  assign fault         = fault_reg;
  assign fault_code    = fault_code_reg;
  assign ld_valid      = done_reg && !we_reg;
  assign ld_funct3     = ld_funct3_reg;
  assign rdata_aligned = rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, done, fault, ld_valid, mem_req, mem_we;
  logic [1:0]  fault_code;
  logic [2:0]  ld_funct3;
  logic [31:0] rdata_aligned, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_load(req_load), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
    .ld_valid(ld_valid), .ld_funct3(ld_funct3), .rdata_aligned(rdata_aligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    tests_run++;
    if ({busy, done, fault, fault_code, ld_valid, ld_funct3, mem_req, mem_we} !== 10'd0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b expected 0", {busy, done, fault, fault_code, ld_valid, ld_funct3, mem_req, mem_we});
    end
    tests_run++;
    if ({rdata_aligned, mem_addr, mem_be, mem_wdata} !== 100'd0) begin
      tests_failed++; $display("FAIL reset_data: rdata %h addr %h be %b wdata %h expected 0", rdata_aligned, mem_addr, mem_be, mem_wdata);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_lw();
    present(1'b1, 3'd2, 32'h100, 32'h0);
    tests_run++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL lw_accept: busy %b mem_req %b expected 1 0", busy, mem_req); end
    step(); // cycle 1
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL lw_bus: req %b addr %h be %b we %b expected 1 00000100 1111 0", mem_req, mem_addr, mem_be, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step(); // cycle 2
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || ld_valid !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin
      tests_failed++; $display("FAIL lw_done: done %b ld_valid %b req %b busy %b fault %b expected 1 1 0 0 0", done, ld_valid, mem_req, busy, fault);
    end
    tests_run++;
    if (rdata_aligned !== 32'hDEADBEEF || ld_funct3 !== 3'd2) begin
      tests_failed++; $display("FAIL lw_data: rdata %h f3 %0d expected deadbeef 2", rdata_aligned, ld_funct3);
    end
    req_valid = 1'b0;
    step();
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL lw_pulse: done %b expected 0", done); end
    $display("[TB] LW 0x100 -> %h", rdata_aligned);
  endtask

  task automatic test_lb_wait();
    present(1'b1, 3'd0, 32'h103, 32'h0);
    step(); // cycle 1
    tests_run++;
    if (mem_be !== 4'b1000 || mem_addr !== 32'h100) begin tests_failed++; $display("FAIL lb_be: be %b addr %h expected 1000 00000100", mem_be, mem_addr); end
    for (int c = 2; c <= 4; c++) begin
      step();
      tests_run++;
      if (mem_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
        tests_failed++; $display("FAIL lb_wait: cycle %0d req %b done %b busy %b expected 1 0 1", c, mem_req, done, busy);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'h80112233;
    step(); // cycle 5
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || rdata_aligned !== 32'h00000080 || ld_funct3 !== 3'd0) begin
      tests_failed++; $display("FAIL lb_done: done %b rdata %h f3 %0d expected 1 00000080 0", done, rdata_aligned, ld_funct3);
    end
    req_valid = 1'b0;
    step();
    $display("[TB] LB 0x103 -> %h", rdata_aligned);
  endtask

  task automatic test_sh_store();
    present(1'b0, 3'd1, 32'h202, 32'h0000ABCD);
    step();
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h200) begin
      tests_failed++; $display("FAIL sh_bus: req %b we %b be %b wdata %h addr %h expected 1 1 1100 abcdabcd 00000200", mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || ld_valid !== 1'b0 || rdata_aligned !== 32'h00000080) begin
      tests_failed++; $display("FAIL sh_done: done %b ld_valid %b rdata %h expected 1 0 00000080", done, ld_valid, rdata_aligned);
    end
    req_valid = 1'b0;
    step();
    $display("[TB] SH 0x202 wdata %h", 32'h0000ABCD);
  endtask

  task automatic test_faults();
    logic        ld_t   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t   [5] = '{3'd1, 3'd3, 3'd4, 3'd3, 3'd2};
    logic [31:0] addr_t [5] = '{32'h101, 32'h100, 32'h100, 32'h101, 32'h302};
    logic [1:0]  code_t [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 5; i++) begin
      present(ld_t[i], f3_t[i], addr_t[i], 32'h0);
      tests_run++;
      if (busy !== 1'b1 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fault_req[%0d]: busy %b mem_req %b expected 1 0", i, busy, mem_req); end
      step();
      tests_run++;
      if (fault !== 1'b1 || fault_code !== code_t[i] || done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
        tests_failed++; $display("FAIL fault[%0d]: fault %b code %b done %b req %b busy %b expected 1 %b 0 0 0", i, fault, fault_code, done, mem_req, busy, code_t[i]);
      end
      req_valid = 1'b0;
      step();
      tests_run++;
      if (fault !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fault_pulse[%0d]: fault %b req %b expected 0 0", i, fault, mem_req); end
      $display("[TB] fault vector %0d code %b", i, fault_code);
    end
  endtask

  task automatic test_timeout();
    present(1'b1, 3'd2, 32'h400, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      step();
      tests_run++;
      if (mem_req !== 1'b1 || fault !== 1'b0) begin tests_failed++; $display("FAIL to_wait: cycle %0d req %b fault %b expected 1 0", c, mem_req, fault); end
    end
    step(); // cycle 6 = 5 cycles after mem_req rose
    tests_run++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL to_fault: fault %b code %b req %b done %b busy %b expected 1 10 0 0 0", fault, fault_code, mem_req, done, busy);
    end
    req_valid = 1'b0;
    step();
    $display("[TB] LW 0x400 timeout code %b", fault_code);
  endtask

  task automatic test_ack_at_timeout();
    present(1'b1, 3'd2, 32'h500, 32'h0);
    for (int c = 1; c <= 4; c++) step();
    step(); // cycle 5: counter at limit
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    step();
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || fault !== 1'b0 || rdata_aligned !== 32'h11223344) begin
      tests_failed++; $display("FAIL ack_at_to: done %b fault %b rdata %h expected 1 0 11223344", done, fault, rdata_aligned);
    end
    req_valid = 1'b0;
    step();
    $display("[TB] LW 0x500 ack at timeout -> %h", rdata_aligned);
  endtask

  task automatic test_back_to_back();
    present(1'b1, 3'd2, 32'h600, 32'h0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    step(); // done cycle; present next request now
    mem_ack = 1'b0;
    present(1'b0, 3'd0, 32'h301, 32'h0000005A);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_done: done %b busy %b req %b expected 1 0 0", done, busy, mem_req);
    end
    step(); // new request evaluated here
    tests_run++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL b2b_eval: busy %b req %b expected 1 0", busy, mem_req); end
    step();
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A || mem_addr !== 32'h300) begin
      tests_failed++; $display("FAIL b2b_bus: req %b we %b be %b wdata %h addr %h expected 1 1 0010 5a5a5a5a 00000300", mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || ld_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_sb_done: done %b ld_valid %b expected 1 0", done, ld_valid); end
    req_valid = 1'b0;
    step();
    $display("[TB] back-to-back LW 0x600 then SB 0x301");
  endtask

  task automatic test_reset_mid_bus();
    present(1'b1, 3'd2, 32'h100, 32'h0);
    step(); step(); // two cycles into BUS
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid: req %b busy %b done %b expected 0 0 0", mem_req, busy, done);
    end
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0 || rdata_aligned !== 32'h0) begin
      tests_failed++; $display("FAIL rst_late_ack: done %b fault %b req %b rdata %h expected 0 0 0 0", done, fault, mem_req, rdata_aligned);
    end
    step();
    present(1'b1, 3'd2, 32'h104, 32'h0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || rdata_aligned !== 32'hCAFEF00D || ld_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rst_recover: done %b rdata %h ld_valid %b expected 1 cafef00d 1", done, rdata_aligned, ld_valid);
    end
    req_valid = 1'b0;
    step();
    $display("[TB] reset mid-bus, then LW 0x104 -> %h", rdata_aligned);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_wait();
    test_sh_store();
    test_faults();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
